// File: rtl/mcs6530_timer.sv
// Interval timer of the MCS6530: 8-bit down-counter behind a selectable
// /1, /8, /64 or /1024 prescaler, with an underflow flag and an active-low interrupt.
module mcs6530_timer #(
   parameter int DIV_SEL_W = 2
) (
   input  logic                 phi2,
   input  logic                 rst_n,
   input  logic                 wr_timer,
   input  logic                 rd_timer,
   input  logic [DIV_SEL_W-1:0] div_sel,
   input  logic                 irq_en_in,
   input  logic [7:0]           din,
   output logic [7:0]           count,
   output logic                 flag,
   output logic                 irq_n
);

   logic                 run, run_nxt;
   logic                 irq_en, irq_en_nxt;
   logic [DIV_SEL_W-1:0] sel, sel_nxt;
   logic [9:0]           pre, pre_nxt;
   logic [7:0]           count_nxt;
   logic                 flag_nxt;
   // fast marks that the timer has expired: from then on it counts at /1 until
   // the next write, even if a read has cleared the flag.
   logic                 fast, fast_nxt;
   logic                 underflow;

   function automatic logic [9:0] reload(input logic [1:0] s);
      case (s)
         2'b00:   reload = 10'd0;
         2'b01:   reload = 10'd7;
         2'b10:   reload = 10'd63;
         default: reload = 10'd1023;
      endcase
   endfunction

   assign underflow = run && (pre == 10'd0) && (count == 8'h00);

   always_comb begin
      count_nxt  = count;
      pre_nxt    = pre;
      sel_nxt    = sel;
      irq_en_nxt = irq_en;
      flag_nxt   = flag;
      run_nxt    = run;
      fast_nxt   = fast;
      if (wr_timer) begin
         count_nxt  = din;
         sel_nxt    = div_sel;
         irq_en_nxt = irq_en_in;
         pre_nxt    = reload(div_sel[1:0]);
         flag_nxt   = 1'b0;
         run_nxt    = 1'b1;
         fast_nxt   = 1'b0;
      end else begin
         if (run) begin
            if (pre != 10'd0) begin
               pre_nxt = pre - 10'd1;
            end else begin
               count_nxt = count - 8'd1;
               if (count == 8'h00)
                  fast_nxt = 1'b1;
               pre_nxt = fast_nxt ? 10'd0 : reload(sel[1:0]);
            end
         end
         // set beats clear when a read lands on the underflow cycle
         if (underflow)
            flag_nxt = 1'b1;
         else if (rd_timer)
            flag_nxt = 1'b0;
      end
   end

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 8'h00;
         pre    <= 10'd0;
         sel    <= '0;
         irq_en <= 1'b0;
         flag   <= 1'b0;
         run    <= 1'b0;
         fast   <= 1'b0;
      end else begin
         count  <= count_nxt;
         pre    <= pre_nxt;
         sel    <= sel_nxt;
         irq_en <= irq_en_nxt;
         flag   <= flag_nxt;
         run    <= run_nxt;
         fast   <= fast_nxt;
      end
   end

   assign irq_n = ~(flag & irq_en);

endmodule

// File: tb/tb_mcs6530_timer.sv
// Self-checking bench for mcs6530_timer: a vector table for the /1 corner
// cases plus model-driven countdown sequences for the prescaled rates and reset.
module tb_mcs6530_timer;

   logic       phi2 = 1'b0;
   logic       rst_n;
   logic       wr_timer, rd_timer, irq_en_in;
   logic [1:0] div_sel;
   logic [7:0] din;
   logic [7:0] count;
   logic       flag, irq_n;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [7:0] count;
      logic       flag;
      logic       irq_n;
      string      name;
   } exp_t;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [1:0] sel;
      logic       ie;
      logic [7:0] din;
      logic [7:0] ecount;
      logic       eflag;
      logic       eirq_n;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];

   mcs6530_timer #(.DIV_SEL_W(2)) dut (
      .phi2      (phi2),
      .rst_n     (rst_n),
      .wr_timer  (wr_timer),
      .rd_timer  (rd_timer),
      .div_sel   (div_sel),
      .irq_en_in (irq_en_in),
      .din       (din),
      .count     (count),
      .flag      (flag),
      .irq_n     (irq_n)
   );

   always #5 phi2 = ~phi2;

   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty: no expected entry, count=%02h flag=%0b", count, flag);
      end else begin
         e = sb.pop_front();
         n_total++;
         if (count === e.count && flag === e.flag && irq_n === e.irq_n)
            n_pass++;
         else
            $display("FAIL %s: got count=%02h flag=%0b irq_n=%0b, want count=%02h flag=%0b irq_n=%0b",
                     e.name, count, flag, irq_n, e.count, e.flag, e.irq_n);
      end
   endtask

   task automatic apply(input logic wr, input logic rd, input logic [1:0] sel,
                        input logic ie, input logic [7:0] d, input exp_t e);
      wr_timer  = wr;
      rd_timer  = rd;
      div_sel   = sel;
      irq_en_in = ie;
      din       = d;
      sb.push_back(e);
      @(posedge phi2);
      #1;
      check();
   endtask

   // Write D at cycle 0, then follow the countdown for ncyc cycles using a
   // closed-form model: D held N cycles per step, then /1 wrap with flag set.
   task automatic run_model(input logic [7:0] d, input logic [1:0] sel,
                            input logic ie, input int ncyc, input string tag);
      int   n;
      int   t;
      exp_t e;
      n = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 8 : (sel == 2'd2) ? 64 : 1024;
      for (int k = 1; k <= ncyc; k++) begin
         t = k - 1;
         if (t < n * (int'(d) + 1)) begin
            e.count = 8'(int'(d) - t / n);
            e.flag  = 1'b0;
         end else begin
            e.count = 8'(255 - (t - n * (int'(d) + 1)));
            e.flag  = 1'b1;
         end
         e.irq_n = ~(e.flag & ie);
         e.name  = $sformatf("%s_c%0d", tag, k);
         apply(k == 1, 1'b0, sel, ie, d, e);
      end
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; wr_timer = 1'b0; rd_timer = 1'b0;
      div_sel = 2'd0; irq_en_in = 1'b0; din = 8'h00;
      #1;
      sb.push_back('{8'h00, 1'b0, 1'b1, "reset_state"});
      check();
      #12;
      rst_n = 1'b1;
      @(posedge phi2);
      #1;

      //              wr    rd    sel   ie    din    count  flag  irq_n
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}); // stopped after reset
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 8'h03, 8'h03, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0}); // underflow
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFD, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'hFC, 1'b0, 1'b1}); // read clears
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFA, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0}); // read on underflow: set wins
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b1}); // write on underflow wins
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}); // irq disabled
      tbl.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         e.count = tbl[i].ecount;
         e.flag  = tbl[i].eflag;
         e.irq_n = tbl[i].eirq_n;
         e.name  = $sformatf("vec%0d", i);
         apply(tbl[i].wr, tbl[i].rd, tbl[i].sel, tbl[i].ie, tbl[i].din, e);
      end

      run_model(8'h02, 2'd1, 1'b1, 26,   "div8_d2");
      run_model(8'h00, 2'd1, 1'b1, 12,   "div8_d0");
      run_model(8'h01, 2'd2, 1'b1, 131,  "div64_d1");
      run_model(8'h05, 2'd2, 1'b1, 10,   "div64_interrupted");
      run_model(8'h02, 2'd0, 1'b1, 6,    "rewrite_div1");
      run_model(8'h01, 2'd3, 1'b0, 2051, "div1024_noirq");

      run_model(8'h05, 2'd2, 1'b1, 100,  "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back('{8'h00, 1'b0, 1'b1, "rst_async"});
      check();
      @(posedge phi2);
      #1;
      sb.push_back('{8'h00, 1'b0, 1'b1, "rst_held"});
      check();
      rst_n = 1'b1;
      for (int k = 0; k < 2000; k++)
         apply(1'b0, 1'b0, 2'd2, 1'b0, 8'h00, '{8'h00, 1'b0, 1'b1, $sformatf("post_rst_c%0d", k)});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
